alu_seq16: RTL and testbench
============================

ALU_SEQ16 -- requirements
Module: alu_seq16

Interface
REQ-001 The block SHALL have one parameter: NNIB, default 4, meaning the number of 4-bit nibbles per operand (operand width = 4*NNIB = 16).
REQ-002 The block SHALL use one clock; reset is synchronous and active-low.
REQ-003 clk  input  1  the single clock; all state changes on its rising edge.
REQ-004 rst_n  input  1  synchronous active-low reset.
REQ-005 start  input  1  request to begin an operation; sampled only in IDLE.
REQ-006 a  input  16  operand A; latched when start is accepted.
REQ-007 b  input  16  operand B; latched when start is accepted.
REQ-008 s  input  4  function select; latched when start is accepted.
REQ-009 m  input  1  mode, 0 = arithmetic, 1 = logic; latched when start is accepted.
REQ-010 cin  input  1  word carry-in; latched when start is accepted.
REQ-011 alu_a, alu_b  output  4 each  nibble operands driven to the external 4-bit ALU slice.
REQ-012 alu_s  output  4  select to the slice; alu_m  output  1  mode to the slice; alu_cin  output  1  carry-in to the slice.
REQ-013 alu_o  input  4  slice result (combinational from the alu_* outputs).
REQ-014 alu_cout  input  1  slice carry-out (0 in logic mode).
REQ-015 busy  output  1  high whenever state is not IDLE.
REQ-016 done  output  1  one-cycle pulse marking result valid.
REQ-017 res  output  16  assembled word result.
REQ-018 cout  output  1  word carry-out, equal to the carry of the last nibble.
REQ-019 zero  output  1  high when res equals 16'h0000.

Function
REQ-020 The FSM SHALL have exactly three states, IDLE, RUN and DONE, with the transitions IDLE->RUN on start=1, RUN->DONE after the nibble with idx=NNIB-1, and DONE->IDLE unconditionally.
REQ-021 On accepting start in IDLE, the block SHALL latch a, b, s, m and cin, clear idx to 0 and clear res to 0.
REQ-022 In RUN with index idx, the block SHALL drive alu_a=a_reg[4*idx+3:4*idx], alu_b=b_reg[4*idx+3:4*idx], alu_s=s_reg and alu_m=m_reg.
REQ-023 In RUN, alu_cin SHALL equal cin_reg when idx=0 and the registered alu_cout of nibble idx-1 when idx>0 (ripple across cycles).
REQ-024 Each RUN cycle SHALL write alu_o into res[4*idx+3:4*idx], register alu_cout into the carry register and increment idx.
REQ-025 In IDLE and DONE, all alu_* outputs SHALL be driven to 0.
REQ-026 Latency: with start sampled at edge T, RUN SHALL occupy cycles T+1..T+NNIB and done SHALL be high for exactly cycle T+NNIB+1 (T+5 at default).
REQ-027 cout SHALL equal the carry register value after the final nibble; in logic mode the block SHALL pass alu_cout through unmodified (expected 0).
REQ-028 res, cout and zero SHALL hold their values from the DONE cycle until the next accepted start.
REQ-029 A start asserted in RUN or DONE SHALL be ignored with no queuing; changes to a, b, s, m or cin while busy SHALL have no effect.
REQ-030 Back-to-back: start held high continuously SHALL yield one operation every NNIB+2 cycles.

Reset
REQ-031 When rst_n=0 at a clock edge, the block SHALL enter IDLE and set idx=0, res=0, cout=0, busy=0, done=0, all latched operands to 0 and all alu_* outputs to 0.
REQ-032 Reset asserted mid-RUN SHALL abort the operation with no done pulse, and the next start after release SHALL behave as from power-up.
REQ-033 When start and rst_n=0 are both asserted in the same cycle, reset SHALL win and start SHALL be discarded.

Verification (bench models the slice: m=0,s=1001 is A+B+cin; m=1 gives the per-bit logic function)
REQ-034 m=0, s=1001, a=16'h00FF, b=16'h0001, cin=0, start at T -> done at T+5, res=16'h0100, cout=0, zero=0.
REQ-035 m=0, s=1001, a=16'hFFFF, b=16'h0001, cin=0 -> res=16'h0000, cout=1, zero=1; alu_cin=1 observed for nibbles 1-3.
REQ-036 m=1, s=0110 (XOR), a=16'hF0F0, b=16'hFF00 -> res=16'h0FF0, cout=0.
REQ-037 Start pulsed again at T+2 with different operands during the REQ-034 operation -> it is ignored and the REQ-034 result is unchanged.
REQ-038 rst_n=0 at T+3 of an operation -> no done pulse, busy=0 and res=0 on the next cycle; a fresh start then completes correctly.
REQ-039 start held high for 3 operations -> done pulses at T+5, T+11 and T+17, with operands latched at T, T+6 and T+12.

Source files
------------

// File: rtl/alu_seq16.sv
// Word ALU that runs one nibble per cycle through an external 4-bit slice.
// Carry ripples between nibbles through a register.
module alu_seq16 #(
    parameter int NNIB = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [4*NNIB-1:0] a,
    input  logic [4*NNIB-1:0] b,
    input  logic [3:0]        s,
    input  logic              m,
    input  logic              cin,
    output logic [3:0]        alu_a,
    output logic [3:0]        alu_b,
    output logic [3:0]        alu_s,
    output logic              alu_m,
    output logic              alu_cin,
    input  logic [3:0]        alu_o,
    input  logic              alu_cout,
    output logic              busy,
    output logic              done,
    output logic [4*NNIB-1:0] res,
    output logic              cout,
    output logic              zero
);

    localparam int W  = 4 * NNIB;
    localparam int IW = (NNIB > 1) ? $clog2(NNIB) : 1;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]    state_q, state_d;
    logic [IW-1:0] idx_q, idx_d;
    logic [W-1:0]  a_q, a_d;
    logic [W-1:0]  b_q, b_d;
    logic [3:0]    s_q, s_d;
    logic          m_q, m_d;
    logic          cin_q, cin_d;
    logic          carry_q, carry_d;
    logic [W-1:0]  res_q, res_d;
    logic [IW+1:0] base;

    // Bit offset of the current nibble.
    assign base = {idx_q, 2'b00};

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        a_d     = a_q;
        b_d     = b_q;
        s_d     = s_q;
        m_d     = m_q;
        cin_d   = cin_q;
        carry_d = carry_q;
        res_d   = res_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_RUN;
                    idx_d   = '0;
                    a_d     = a;
                    b_d     = b;
                    s_d     = s;
                    m_d     = m;
                    cin_d   = cin;
                    carry_d = 1'b0;
                    res_d   = '0;
                end
            end
            S_RUN: begin
                res_d[base +: 4] = alu_o;
                carry_d          = alu_cout;
                idx_d            = idx_q + IW'(1);
                if (idx_q == IW'(NNIB - 1)) begin
                    state_d = S_DONE;
                    idx_d   = '0;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        alu_a   = 4'h0;
        alu_b   = 4'h0;
        alu_s   = 4'h0;
        alu_m   = 1'b0;
        alu_cin = 1'b0;
        if (state_q == S_RUN) begin
            alu_a   = a_q[base +: 4];
            alu_b   = b_q[base +: 4];
            alu_s   = s_q;
            alu_m   = m_q;
            alu_cin = (idx_q == '0) ? cin_q : carry_q;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            idx_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            s_q     <= '0;
            m_q     <= 1'b0;
            cin_q   <= 1'b0;
            carry_q <= 1'b0;
            res_q   <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            a_q     <= a_d;
            b_q     <= b_d;
            s_q     <= s_d;
            m_q     <= m_d;
            cin_q   <= cin_d;
            carry_q <= carry_d;
            res_q   <= res_d;
        end
    end

    assign busy = (state_q != S_IDLE);
    assign done = (state_q == S_DONE);
    assign res  = res_q;
    assign cout = carry_q;
    assign zero = (res_q == '0);

endmodule

// File: tb/tb_alu_seq16.sv
// Directed bench for alu_seq16 with a behavioural 4-bit slice.
// Expected results are hand-computed constants.
module tb_alu_seq16;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [15:0] a, b;
    logic [3:0]  s;
    logic        m, cin;
    logic [3:0]  alu_a, alu_b, alu_s;
    logic        alu_m, alu_cin;
    logic [3:0]  alu_o;
    logic        alu_cout;
    logic        busy, done, cout, zero;
    logic [15:0] res;

    int checks = 0;
    int errors = 0;

    alu_seq16 #(.NNIB(4)) dut (
        .clk(clk), .rst_n(rst_n), .start(start),
        .a(a), .b(b), .s(s), .m(m), .cin(cin),
        .alu_a(alu_a), .alu_b(alu_b), .alu_s(alu_s),
        .alu_m(alu_m), .alu_cin(alu_cin),
        .alu_o(alu_o), .alu_cout(alu_cout),
        .busy(busy), .done(done), .res(res),
        .cout(cout), .zero(zero)
    );

    always #5 clk = ~clk;

    // Slice model: arithmetic is A+B+cin; logic covers the used functions.
    always_comb begin
        logic [4:0] sum;
        sum      = {1'b0, alu_a} + {1'b0, alu_b} + {4'b0, alu_cin};
        alu_o    = sum[3:0];
        alu_cout = sum[4];
        if (alu_m) begin
            alu_cout = 1'b0;
            case (alu_s)
                4'b0110: alu_o = alu_a ^ alu_b;
                4'b1011: alu_o = alu_a & alu_b;
                4'b1110: alu_o = alu_a | alu_b;
                default: alu_o = ~alu_a;
            endcase
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic drive(input logic [15:0] ai, input logic [15:0] bi,
                         input logic [3:0] si, input logic mi,
                         input logic ci);
        a   = ai;
        b   = bi;
        s   = si;
        m   = mi;
        cin = ci;
    endtask

    // Starts an op and returns edges from the start edge to done.
    task automatic go(output int lat);
        start = 1'b1;
        tick();
        start = 1'b0;
        lat = 0;
        while (!done && lat < 10) begin
            tick();
            lat++;
        end
    endtask

    int lat;

    initial begin
        rst_n = 1'b0;
        start = 1'b0;
        drive(16'h0, 16'h0, 4'h0, 1'b0, 1'b0);
        tick();
        tick();
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_res", res, 0);
        chk("rst_cout", cout, 0);
        chk("rst_zero", zero, 1);
        chk("rst_alu", {alu_a, alu_b, alu_s, alu_m, alu_cin}, 0);
        rst_n = 1'b1;
        tick();

        // 00FF + 0001, with an ignored start pulse at T+2.
        drive(16'h00FF, 16'h0001, 4'b1001, 1'b0, 1'b0);
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("add_busy", busy, 1);
        chk("add_alua0", alu_a, 4'hF);
        tick();
        drive(16'hFFFF, 16'hFFFF, 4'b0110, 1'b1, 1'b1);
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        chk("add_nodone", done, 0);
        tick();
        chk("add_done", done, 1);
        chk("add_res", res, 16'h0100);
        chk("add_cout", cout, 0);
        chk("add_zero", zero, 0);
        tick();
        chk("add_pulse", done, 0);
        chk("add_idle", busy, 0);
        chk("add_hold", res, 16'h0100);
        chk("idle_alu", {alu_a, alu_b, alu_s, alu_m, alu_cin}, 0);

        // FFFF + 0001: carry ripples through every nibble.
        drive(16'hFFFF, 16'h0001, 4'b1001, 1'b0, 1'b0);
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("ovf_cin0", alu_cin, 0);
        for (int i = 1; i < 4; i++) begin
            tick();
            chk($sformatf("ovf_cin%0d", i), alu_cin, 1);
        end
        tick();
        chk("ovf_done", done, 1);
        chk("ovf_res", res, 16'h0000);
        chk("ovf_cout", cout, 1);
        chk("ovf_zero", zero, 1);
        tick();

        // Logic mode XOR and AND.
        drive(16'hF0F0, 16'hFF00, 4'b0110, 1'b1, 1'b0);
        go(lat);
        chk("xor_lat", lat, 4);
        chk("xor_res", res, 16'h0FF0);
        chk("xor_cout", cout, 0);
        tick();
        drive(16'hF0F0, 16'hFF00, 4'b1011, 1'b1, 1'b1);
        go(lat);
        chk("and_lat", lat, 4);
        chk("and_res", res, 16'hF000);
        chk("and_cout", cout, 0);
        tick();

        // Reset at T+3 aborts; reset beats a simultaneous start.
        drive(16'h1234, 16'h1111, 4'b1001, 1'b0, 1'b0);
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        tick();
        rst_n = 1'b0;
        tick();
        chk("ab_busy", busy, 0);
        chk("ab_done", done, 0);
        chk("ab_res", res, 0);
        start = 1'b1;
        tick();
        chk("rs_busy", busy, 0);
        rst_n = 1'b1;
        start = 1'b0;
        tick();
        drive(16'h1234, 16'h1111, 4'b1001, 1'b0, 1'b1);
        go(lat);
        chk("fr_lat", lat, 4);
        chk("fr_res", res, 16'h2346);
        chk("fr_cout", cout, 0);
        tick();

        // Start held high: three ops, 6 cycles apart.
        drive(16'h0001, 16'h0001, 4'b1001, 1'b0, 1'b0);
        start = 1'b1;
        tick();
        drive(16'h8000, 16'h8000, 4'b1001, 1'b0, 1'b0);
        for (int k = 1; k <= 17; k++) begin
            tick();
            chk($sformatf("b2b_done%0d", k), done,
                (k == 4 || k == 10 || k == 16));
            if (k == 4) chk("b2b_res1", res, 16'h0002);
            if (k == 6) drive(16'h7FFF, 16'h0001, 4'b1001, 1'b0, 1'b0);
            if (k == 10) chk("b2b_res2", {15'h0, cout, res}, 32'h10000);
            if (k == 12) start = 1'b0;
            if (k == 16) chk("b2b_res3", {15'h0, cout, res}, 32'h08000);
        end
        chk("b2b_idle", busy, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
